// File: rtl/sram_io_unit.sv
// sram_io_unit: per anchor step, fetches one WINDOW-tall pixel column from SRAM and writes back the lagged result pixel.
// Optional feature: define SRAM_IO_PROTOCOL_CHECK_EN to flag anchor_moving pulses that arrive while a step is in progress.
module sram_io_unit #(
    parameter int WINDOW   = 5,
    parameter int PIX_W    = 8,
    parameter int X_OFFSET = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    anchor_moving,
    input  logic                    read_enable,
    input  logic                    write_enable,
    input  logic [31:0]             anchor_x,
    input  logic [31:0]             anchor_y,
    input  logic [31:0]             width,
    input  logic [31:0]             height,
    input  logic [31:0]             read_base,
    input  logic [31:0]             write_base,
    input  logic [PIX_W-1:0]        result_pixel,
    output logic [31:0]             sram_addr,
    output logic                    sram_rd,
    output logic                    sram_wr,
    output logic [PIX_W-1:0]        sram_wdata,
    input  logic [PIX_W-1:0]        sram_rdata,
    input  logic                    sram_ready,
    output logic [WINDOW*PIX_W-1:0] column_pixels,
    output logic                    column_valid,
    output logic                    io_final,
    output logic                    protocol_error
);

    localparam int ROW_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WINDOW - 1);
    localparam logic [31:0] XOFF = 32'(X_OFFSET);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STORE,
        SKIP
    } state_t;

    function automatic logic row_in_bounds(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] w, input logic [31:0] h,
                                           input logic [31:0] i);
        logic [31:0] row_y;
        row_y = y + i;
        return (x < w) && (row_y < h);
    endfunction

    function automatic logic [31:0] read_addr(input logic [31:0] base, input logic [31:0] x,
                                              input logic [31:0] y, input logic [31:0] w,
                                              input logic [31:0] i);
        logic [31:0] row_y;
        logic [31:0] row_off;
        row_y   = y + i;
        row_off = row_y * w;
        return base + row_off + x;
    endfunction

    function automatic logic store_in_bounds(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] w, input logic [31:0] h);
        logic [31:0] x_limit;
        x_limit = w + XOFF;
        return (x >= XOFF) && (x < x_limit) && (y < h);
    endfunction

    function automatic logic [31:0] write_addr(input logic [31:0] base, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] w);
        logic [31:0] row_off;
        row_off = y * w;
        return base + row_off + (x - XOFF);
    endfunction

    state_t                    state;
    logic [ROW_W-1:0]          row;
    logic [31:0]               ax;
    logic [31:0]               ay;
    logic                      wr_en_q;
    logic [PIX_W-1:0]          pix_q;
    logic [WINDOW*PIX_W-1:0]   slots;

    logic                      cur_in;
    logic                      row_done;
    logic [PIX_W-1:0]          row_value;
    logic [WINDOW*PIX_W-1:0]   slots_next;
    logic                      next_in;
    logic [31:0]               next_rd_addr;
    logic                      st_ok;
    logic [31:0]               st_addr;
    logic                      start_in;
    logic [31:0]               start_rd_addr;
    logic                      start_st_ok;
    logic [31:0]               start_st_addr;

    // Request decisions for the current row, the following row, and the store,
    // plus the same decisions evaluated on the raw inputs for the step being accepted.
    always_comb begin
        cur_in        = row_in_bounds(ax, ay, width, height, 32'(row));
        row_done      = !cur_in || sram_ready;
        row_value     = cur_in ? sram_rdata : '0;
        slots_next    = slots;
        slots_next[int'(row)*PIX_W +: PIX_W] = row_value;
        next_in       = row_in_bounds(ax, ay, width, height, 32'(row) + 32'd1);
        next_rd_addr  = read_addr(read_base, ax, ay, width, 32'(row) + 32'd1);
        st_ok         = store_in_bounds(ax, ay, width, height);
        st_addr       = write_addr(write_base, ax, ay, width);
        start_in      = row_in_bounds(anchor_x, anchor_y, width, height, 32'd0);
        start_rd_addr = read_addr(read_base, anchor_x, anchor_y, width, 32'd0);
        start_st_ok   = store_in_bounds(anchor_x, anchor_y, width, height);
        start_st_addr = write_addr(write_base, anchor_x, anchor_y, width);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            row           <= '0;
            ax            <= '0;
            ay            <= '0;
            wr_en_q       <= 1'b0;
            pix_q         <= '0;
            slots         <= '0;
            sram_addr     <= '0;
            sram_rd       <= 1'b0;
            sram_wr       <= 1'b0;
            sram_wdata    <= '0;
            column_pixels <= '0;
            column_valid  <= 1'b0;
            io_final      <= 1'b1;
        end else begin
            column_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (anchor_moving) begin
                        ax       <= anchor_x;
                        ay       <= anchor_y;
                        wr_en_q  <= write_enable;
                        pix_q    <= result_pixel;
                        row      <= '0;
                        io_final <= 1'b0;
                        if (read_enable) begin
                            state   <= FETCH;
                            sram_rd <= start_in;
                            if (start_in) begin
                                sram_addr <= start_rd_addr;
                            end
                        end else if (write_enable) begin
                            state      <= STORE;
                            sram_wr    <= start_st_ok;
                            sram_wdata <= result_pixel;
                            if (start_st_ok) begin
                                sram_addr <= start_st_addr;
                            end
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                FETCH: begin
                    if (row_done) begin
                        slots <= slots_next;
                        if (row == LAST_ROW) begin
                            sram_rd       <= 1'b0;
                            column_pixels <= slots_next;
                            column_valid  <= 1'b1;
                            if (wr_en_q) begin
                                state      <= STORE;
                                sram_wr    <= st_ok;
                                sram_wdata <= pix_q;
                                if (st_ok) begin
                                    sram_addr <= st_addr;
                                end
                            end else begin
                                state    <= IDLE;
                                io_final <= 1'b1;
                            end
                        end else begin
                            row     <= row + 1'b1;
                            sram_rd <= next_in;
                            if (next_in) begin
                                sram_addr <= next_rd_addr;
                            end
                        end
                    end
                end
                STORE: begin
                    // An out-of-range store never raised sram_wr, so it finishes in one cycle.
                    if (!sram_wr || sram_ready) begin
                        sram_wr  <= 1'b0;
                        state    <= IDLE;
                        io_final <= 1'b1;
                    end
                end
                SKIP: begin
                    state    <= IDLE;
                    io_final <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    sram_rd  <= 1'b0;
                    sram_wr  <= 1'b0;
                    io_final <= 1'b1;
                end
            endcase
        end
    end

`ifdef SRAM_IO_PROTOCOL_CHECK_EN
    // Sticky until reset; the stray pulse itself has no other effect.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            protocol_error <= 1'b0;
        end else if (anchor_moving && (state != IDLE)) begin
            protocol_error <= 1'b1;
        end
    end
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_sram_io_unit.sv
// tb_sram_io_unit: directed and randomized anchor steps against a step-level reference model and a latency-configurable SRAM model.
module tb_sram_io_unit;

    localparam int WINDOW   = 5;
    localparam int PIX_W    = 8;
    localparam int X_OFFSET = 4;
    localparam int BUDGET   = 200;

`ifdef SRAM_IO_PROTOCOL_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    logic                    clk;
    logic                    n_rst;
    logic                    anchor_moving;
    logic                    read_enable;
    logic                    write_enable;
    logic [31:0]             anchor_x;
    logic [31:0]             anchor_y;
    logic [31:0]             width;
    logic [31:0]             height;
    logic [31:0]             read_base;
    logic [31:0]             write_base;
    logic [PIX_W-1:0]        result_pixel;
    logic [31:0]             sram_addr;
    logic                    sram_rd;
    logic                    sram_wr;
    logic [PIX_W-1:0]        sram_wdata;
    logic [PIX_W-1:0]        sram_rdata;
    logic                    sram_ready;
    logic [WINDOW*PIX_W-1:0] column_pixels;
    logic                    column_valid;
    logic                    io_final;
    logic                    protocol_error;

    int checks = 0;
    int passed = 0;
    int lat = 0;
    int wait_cnt = 0;

    sram_io_unit #(
        .WINDOW(WINDOW),
        .PIX_W(PIX_W),
        .X_OFFSET(X_OFFSET)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .anchor_moving(anchor_moving),
        .read_enable(read_enable),
        .write_enable(write_enable),
        .anchor_x(anchor_x),
        .anchor_y(anchor_y),
        .width(width),
        .height(height),
        .read_base(read_base),
        .write_base(write_base),
        .result_pixel(result_pixel),
        .sram_addr(sram_addr),
        .sram_rd(sram_rd),
        .sram_wr(sram_wr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_ready(sram_ready),
        .column_pixels(column_pixels),
        .column_valid(column_valid),
        .io_final(io_final),
        .protocol_error(protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] mem_data(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // SRAM model: each access completes after lat wait cycles; read data is garbage outside the ready cycle.
    always @(posedge clk) begin
        if ((sram_rd || sram_wr) && !sram_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign sram_ready = (sram_rd || sram_wr) && (wait_cnt >= lat);
    assign sram_rdata = sram_ready ? mem_data(sram_addr) : 8'hEE;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic apply_stimulus(input logic [31:0] ax, input logic [31:0] ay, input logic re,
                                  input logic we, input logic [PIX_W-1:0] pix, input int latency);
        @(negedge clk);
        lat           = latency;
        anchor_x      = ax;
        anchor_y      = ay;
        read_enable   = re;
        write_enable  = we;
        result_pixel  = pix;
        anchor_moving = 1'b1;
    endtask

    // One full step: model expectations from the addressing rules, then observe every cycle until io_final.
    task automatic run_step(input string tag, input logic [31:0] ax, input logic [31:0] ay,
                            input logic re, input logic we, input logic [PIX_W-1:0] pix,
                            input int latency, input int glitch_off);
        logic [31:0]             exp_reads[$];
        logic [31:0]             got_reads[$];
        logic [WINDOW*PIX_W-1:0] exp_col;
        logic [WINDOW*PIX_W-1:0] got_col;
        logic [31:0]             y;
        logic [31:0]             a;
        logic [31:0]             x_limit;
        logic                    st_ok;
        logic [31:0]             exp_waddr;
        logic [31:0]             got_waddr;
        logic [PIX_W-1:0]        got_wdata;
        int                      fetch_len;
        int                      store_len;
        int                      exp_final;
        int                      exp_colv;
        int                      got_final;
        int                      got_colv;
        int                      colv_cnt;
        int                      wr_cnt;
        logic                    overlap;

        exp_col   = '0;
        fetch_len = 0;
        if (re) begin
            for (int i = 0; i < WINDOW; i++) begin
                y = ay + 32'(i);
                if (ax < width && y < height) begin
                    a = read_base + y * width + ax;
                    exp_reads.push_back(a);
                    exp_col[i*PIX_W +: PIX_W] = mem_data(a);
                    fetch_len += latency + 1;
                end else begin
                    fetch_len += 1;
                end
            end
        end
        x_limit   = width + 32'(X_OFFSET);
        st_ok     = we && (ax >= 32'(X_OFFSET)) && (ax < x_limit) && (ay < height);
        exp_waddr = write_base + ay * width + (ax - 32'(X_OFFSET));
        store_len = !we ? 0 : (st_ok ? latency + 1 : 1);
        exp_final = (!re && !we) ? 2 : 1 + fetch_len + store_len;
        exp_colv  = re ? 1 + fetch_len : -1;

        got_final = -1;
        got_colv  = -1;
        got_col   = '0;
        colv_cnt  = 0;
        wr_cnt    = 0;
        got_waddr = '0;
        got_wdata = '0;
        overlap   = 1'b0;

        apply_stimulus(ax, ay, re, we, pix, latency);
        for (int off = 1; off <= BUDGET; off++) begin
            @(negedge clk);
            anchor_moving = (off == glitch_off);
            if (off == glitch_off) begin
                anchor_x     = $urandom;
                anchor_y     = $urandom;
                read_enable  = 1'($urandom_range(0, 1));
                write_enable = 1'($urandom_range(0, 1));
                result_pixel = PIX_W'($urandom);
            end
            if (glitch_off > 0 && off == glitch_off + 1)
                check_output({tag, "/perr"}, 64'(protocol_error), 64'(EXP_PERR));
            if (sram_rd && sram_wr) overlap = 1'b1;
            if (sram_rd && sram_ready) got_reads.push_back(sram_addr);
            if (sram_wr && sram_ready) begin
                wr_cnt++;
                got_waddr = sram_addr;
                got_wdata = sram_wdata;
            end
            if (column_valid) begin
                colv_cnt++;
                got_colv = off;
                got_col  = column_pixels;
            end
            if (io_final) begin
                got_final = off;
                break;
            end
        end
        anchor_moving = 1'b0;

        check_output({tag, "/final"}, 64'(got_final), 64'(exp_final));
        check_output({tag, "/nreads"}, 64'(got_reads.size()), 64'(exp_reads.size()));
        for (int i = 0; i < exp_reads.size(); i++)
            check_output($sformatf("%s/read%0d", tag, i),
                         (i < got_reads.size()) ? 64'(got_reads[i]) : 64'hDEAD_DEAD_DEAD_DEAD,
                         64'(exp_reads[i]));
        check_output({tag, "/ncolv"}, 64'(colv_cnt), re ? 64'd1 : 64'd0);
        if (re) begin
            check_output({tag, "/colv_at"}, 64'(got_colv), 64'(exp_colv));
            check_output({tag, "/column"}, 64'(got_col), 64'(exp_col));
        end
        check_output({tag, "/nwrites"}, 64'(wr_cnt), st_ok ? 64'd1 : 64'd0);
        if (st_ok) begin
            check_output({tag, "/waddr"}, 64'(got_waddr), 64'(exp_waddr));
            check_output({tag, "/wdata"}, 64'(got_wdata), 64'(pix));
        end
        check_output({tag, "/rd_wr_overlap"}, 64'(overlap), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "/io_final"}, 64'(io_final), 64'd1);
        check_output({tag, "/sram_rd"}, 64'(sram_rd), 64'd0);
        check_output({tag, "/sram_wr"}, 64'(sram_wr), 64'd0);
        check_output({tag, "/column_valid"}, 64'(column_valid), 64'd0);
        check_output({tag, "/protocol_error"}, 64'(protocol_error), 64'd0);
        check_output({tag, "/sram_addr"}, 64'(sram_addr), 64'd0);
        check_output({tag, "/sram_wdata"}, 64'(sram_wdata), 64'd0);
        check_output({tag, "/column_pixels"}, 64'(column_pixels), 64'd0);
    endtask

    initial begin
        n_rst         = 1'b0;
        anchor_moving = 1'b0;
        read_enable   = 1'b0;
        write_enable  = 1'b0;
        anchor_x      = '0;
        anchor_y      = '0;
        result_pixel  = '0;
        width         = 32'd10;
        height        = 32'd8;
        read_base     = 32'h1000;
        write_base    = 32'h2000;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        n_rst = 1'b1;
        @(negedge clk);

        run_step("a6_2",        32'd6,  32'd2, 1'b1, 1'b1, 8'h3C, 0, -1);
        run_step("a3_5",        32'd3,  32'd5, 1'b1, 1'b1, 8'h77, 0, -1);
        run_step("a12_2",       32'd12, 32'd2, 1'b1, 1'b1, 8'h5E, 0, -1);
        run_step("a6_2_late",   32'd6,  32'd2, 1'b1, 1'b1, 8'h91, 2, -1);
        run_step("read_only",   32'd6,  32'd2, 1'b1, 1'b0, 8'h12, 0, -1);
        run_step("write_only",  32'd6,  32'd2, 1'b0, 1'b1, 8'h34, 1, -1);
        run_step("skip",        32'd6,  32'd2, 1'b0, 1'b0, 8'h56, 0, -1);
        run_step("x_max_store", 32'd13, 32'd7, 1'b1, 1'b1, 8'hC3, 0, -1);
        run_step("x_min_store", 32'd4,  32'd0, 1'b1, 1'b1, 8'hE1, 1, -1);
        run_step("x_past",      32'd14, 32'd2, 1'b1, 1'b1, 8'h0F, 0, -1);
        run_step("y_wrap",      32'd0,  32'hFFFF_FFFE, 1'b1, 1'b1, 8'hAA, 0, -1);

        // Async reset during row 2 must drop strobes at once, then a fresh step must work.
        apply_stimulus(32'd6, 32'd2, 1'b1, 1'b1, 8'h66, 0);
        @(negedge clk);
        anchor_moving = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midrst/row2_rd", 64'(sram_rd), 64'd1);
        check_output("midrst/row2_addr", 64'(sram_addr), 64'h102E);
        #2 n_rst = 1'b0;
        #1;
        check_output("midrst/rd_drop", 64'(sram_rd), 64'd0);
        check_output("midrst/wr_drop", 64'(sram_wr), 64'd0);
        check_output("midrst/io_final", 64'(io_final), 64'd1);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_output("midrst/idle_after", 64'(io_final), 64'd1);
        run_step("after_rst", 32'd6, 32'd2, 1'b1, 1'b1, 8'h99, 0, -1);

        for (int n = 0; n < 30; n++) begin
            run_step($sformatf("rand%0d", n),
                     32'($urandom_range(0, 15)), 32'($urandom_range(0, 10)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     PIX_W'($urandom), int'($urandom_range(0, 2)), -1);
        end

        run_step("glitch", 32'd6, 32'd2, 1'b1, 1'b1, 8'h4D, 0, 3);
        check_output("glitch/sticky", 64'(protocol_error), 64'(EXP_PERR));
        run_step("glitch_late", 32'd8, 32'd1, 1'b1, 1'b1, 8'hB2, 1, 5);
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check_output("glitch/cleared", 64'(protocol_error), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
